// File: rtl/row_scan_reader.sv
// Snapshots one addressed row of a flattened ROWS x COLS bit array and streams it
// LSB first over a valid/ready serial link. `ROW_PARITY_EN appends an even-parity beat.
module row_scan_reader #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  localparam int ADDR_W = $clog2(ROWS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ROWS*COLS-1:0] mem_bits,
  input  logic                 rd_req,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic                 rd_busy,
  output logic                 addr_err,
  output logic                 ser_valid,
  input  logic                 ser_ready,
  output logic                 ser_data,
  output logic                 ser_last,
  output logic                 rd_done
);

`ifdef ROW_PARITY_EN
  localparam int NBEATS = COLS + 1;
`else
  localparam int NBEATS = COLS;
`endif
  localparam int CNT_W = $clog2(COLS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);
  localparam logic [ADDR_W:0] ROWS_EXT = (ADDR_W + 1)'(ROWS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NBEATS-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, addr_err_q, valid_q, data_q, last_q, done_q;
  logic               busy_d, addr_err_d, valid_d, data_d, last_d, done_d;

  logic [COLS-1:0]    rows_s [ROWS];
  logic [COLS-1:0]    row_sel_s;
  logic [NBEATS-1:0]  capture_s;
  logic               addr_ok_s;

  for (genvar r = 0; r < ROWS; r++) begin : g_rows
    assign rows_s[r] = mem_bits[r*COLS +: COLS];
  end

  // Row select and capture word; the parity bit rides above the data so shifting delivers it last
  always_comb begin
    row_sel_s = rows_s[rd_addr];
    addr_ok_s = ({1'b0, rd_addr} < ROWS_EXT);
`ifdef ROW_PARITY_EN
    capture_s = {^row_sel_s, row_sel_s};
`else
    capture_s = row_sel_s;
`endif
  end

  // Next-state logic for the read FSM, shift register and beat counter
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    addr_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req && addr_ok_s) begin
          shift_d = capture_s;
          cnt_d   = '0;
          state_d = SHIFT;
        end else if (rd_req) begin
          addr_err_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (ser_ready) begin
          shift_d = shift_q >> 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = SHIFT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next state so they leave the block straight from flops
  always_comb begin
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == SHIFT);
    done_d  = (state_d == DONE);
    if (state_d == SHIFT) begin
      data_d = shift_d[0];
      last_d = (cnt_d == LAST_BEAT);
    end else begin
      data_d = 1'b0;
      last_d = 1'b0;
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      addr_err_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      addr_err_q <= addr_err_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      last_q     <= last_d;
      done_q     <= done_d;
    end
  end

  assign rd_busy   = busy_q;
  assign addr_err  = addr_err_q;
  assign ser_valid = valid_q;
  assign ser_data  = data_q;
  assign ser_last  = last_q;
  assign rd_done   = done_q;

endmodule

// File: doc/row_scan_reader.md
Name: row_scan_reader

Overview:
- Read side of the row storage array.
- Takes the flattened contents of ROWS x COLS row flip-flops and, on request, snapshots one addressed row.
- Streams the snapshot out one bit per beat, LSB first, over a valid/ready serial interface.
- Sits between the row register bank and the downstream serial consumer (display/UART/checker).

Parameters:
- ROWS, 8, number of stored rows.
- COLS, 8, bits per row (>= 2).
- ADDR_W, $clog2(ROWS) (3 at default), width of the row address; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_bits  input  ROWS*COLS  flattened row array; row r = mem_bits[r*COLS +: COLS].
- rd_req  input  1  read request, sampled only in IDLE.
- rd_addr  input  ADDR_W  row to read, sampled with rd_req.
- rd_busy  output  1  high in every state except IDLE.
- addr_err  output  1  one-cycle pulse when rd_req arrives in IDLE with rd_addr >= ROWS.
- ser_valid  output  1  serial bit valid.
- ser_ready  input  1  consumer accepts the bit.
- ser_data  output  1  current serial bit.
- ser_last  output  1  high with ser_valid on the final beat.
- rd_done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset: asynchronous; immediately forces state IDLE, shift register 0, beat counter 0, and all outputs to 0 (rd_busy, addr_err, ser_valid, ser_data, ser_last, rd_done). Reset mid-transfer abandons the transfer; no rd_done is issued.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - rd_req=1 with rd_addr < ROWS: at that edge, capture mem_bits row rd_addr into the shift register, clear the counter, and go to SHIFT. ser_valid goes high in the next cycle, one cycle of latency.
  - rd_req=1 with rd_addr >= ROWS (only possible when ROWS is not a power of 2): pulse addr_err for one cycle and stay in IDLE.
- SHIFT:
  - ser_valid=1 and ser_data = shift_reg[0].
  - The beat completes on an edge with ser_valid & ser_ready. The register then shifts right by 1 and the counter increments.
  - When ser_ready=0, ser_data and ser_last hold stable; ser_valid never drops while waiting.
  - ser_last=1 when the counter equals the final beat index (COLS-1 base).
  - Handshake on the final beat: go to DONE.
- DONE: rd_done=1 for exactly one cycle, ser_valid=0, then IDLE. A new rd_req can be accepted from the following IDLE cycle.
- rd_req is ignored while rd_busy=1. It is neither queued nor flagged.
- Changes on mem_bits after the capture edge do not affect the transfer in progress (snapshot semantics).
- Counter width: $clog2(COLS+1). No wrap within a transfer.
- Throughput with ser_ready held at 1: a transfer of N beats occupies N+1 busy cycles (N in SHIFT plus 1 in DONE).

Optional Feature:
- Macro: ROW_PARITY_EN.
- Defined: one extra beat follows the COLS data bits. It carries even parity of the captured row (XOR of all COLS bits). ser_last moves to the parity beat; a transfer is COLS+1 beats.
- Not defined: exactly COLS beats and no parity logic.

Test Plan (all at ROWS=8, COLS=8):
- Reset/idle: assert reset mid-SHIFT after 3 beats -> all outputs 0 immediately. After release, rd_req addr=2 with row2=8'hA5 -> 8 beats 1,0,1,0,0,1,0,1, ser_last on beat 8, rd_done pulse one cycle later.
- Back-pressure: row5=8'h3C, ser_ready toggles 1,0,0,1,... -> ser_data and ser_last stable during stalls. Stream is 0,0,1,1,1,1,0,0 with no lost or duplicated beat.
- Snapshot: capture row1=8'hFF, then change mem_bits row1 to 8'h00 at beat 2 -> all 8 beats are 1.
- Busy ignore: rd_req addr=4 during a SHIFT of addr=0 -> no second transfer; addr=4 is only served when requested again after rd_done.
- Address error (ROWS=6 build): rd_req addr=7 -> addr_err pulses one cycle, rd_busy stays 0, ser_valid stays 0.
- ROW_PARITY_EN: row3=8'h07 -> 9 beats, 9th beat = 1, ser_last on beat 9. For row3=8'h03, 9th beat = 0.
